// File: rtl/seq_muldiv_unit_if.sv
// Request/response bundle between the datapath and the iterative multiply/divide unit.
interface seq_muldiv_unit_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned OPW   = 5
);
   logic             start;
   logic [OPW-1:0]   opcode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;
   logic             op_err;

   modport master (output start, opcode, a, b,
                   input  busy, done, hi, lo, div_by_zero, op_err);
   modport slave  (input  start, opcode, a, b,
                   output busy, done, hi, lo, div_by_zero, op_err);
endinterface

// File: rtl/seq_muldiv_unit.sv
// Iterative signed Booth multiply / non-restoring divide, one step per clock, results to HI/LO.
// Optional macro MULDIV_ZERO_SKIP_EN: zero-operand cases complete without iterating.
module seq_muldiv_unit #(
   parameter int unsigned    WIDTH  = 32,
   parameter int unsigned    OPW    = 5,
   parameter logic [OPW-1:0] OP_MUL = OPW'(5'b01111),
   parameter logic [OPW-1:0] OP_DIV = OPW'(5'b10000)
) (
   input  logic             clk,
   input  logic             clear,
   seq_muldiv_unit_if.slave bus
);
   localparam int unsigned AW = WIDTH + 2;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [AW-1:0]    r_acc, w_acc_nxt;
   logic [WIDTH-1:0] r_q, w_q_nxt;
   logic             r_q1, w_q1_nxt;
   logic [WIDTH-1:0] r_m, w_m_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic             r_is_div, w_is_div_nxt;
   logic             r_neg_q, w_neg_q_nxt;
   logic             r_neg_r, w_neg_r_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic [WIDTH-1:0] r_hi, w_hi_nxt;
   logic [WIDTH-1:0] r_lo, w_lo_nxt;
   logic             r_dbz, w_dbz_nxt;
   logic             r_op_err, w_op_err_nxt;

   logic             w_is_mul, w_is_divop, w_idle_like, w_accept, w_bad, w_zero_skip;
   logic [WIDTH-1:0] w_a_abs, w_b_abs;
   logic [AW-1:0]    w_booth, w_mul_acc, w_div_sh, w_div_acc;
   logic [WIDTH-1:0] w_mul_q, w_div_q, w_rem_fix, w_quo, w_rem;

   assign w_is_mul    = (bus.opcode == OP_MUL);
   assign w_is_divop  = (bus.opcode == OP_DIV);
   assign w_idle_like = (r_state != S_RUN);
   assign w_accept    = bus.start && w_idle_like && (w_is_mul || w_is_divop);
   assign w_bad       = bus.start && w_idle_like && !(w_is_mul || w_is_divop);
   assign w_a_abs     = bus.a[WIDTH-1] ? ((~bus.a) + WIDTH'(1)) : bus.a;
   assign w_b_abs     = bus.b[WIDTH-1] ? ((~bus.b) + WIDTH'(1)) : bus.b;

`ifdef MULDIV_ZERO_SKIP_EN
   assign w_zero_skip = w_is_mul ? ((bus.a == '0) || (bus.b == '0))
                                 : ((bus.a == '0) && (bus.b != '0));
`else
   assign w_zero_skip = 1'b0;
`endif

   // Booth step: add/subtract sign-extended multiplicand, then arithmetic shift {acc,q,q1}
   always_comb begin
      w_booth = r_acc;
      case ({r_q[0], r_q1})
         2'b01:   w_booth = r_acc + {{2{r_m[WIDTH-1]}}, r_m};
         2'b10:   w_booth = r_acc - {{2{r_m[WIDTH-1]}}, r_m};
         default: w_booth = r_acc;
      endcase
   end
   assign w_mul_acc = {w_booth[AW-1], w_booth[AW-1:1]};
   assign w_mul_q   = {w_booth[0], r_q[WIDTH-1:1]};

   // Non-restoring step on magnitudes; signs are applied when the result is written out
   assign w_div_sh  = {r_acc[AW-2:0], r_q[WIDTH-1]};
   assign w_div_acc = r_acc[AW-1] ? (w_div_sh + {2'b00, r_m}) : (w_div_sh - {2'b00, r_m});
   assign w_div_q   = {r_q[WIDTH-2:0], ~w_div_acc[AW-1]};
   assign w_rem_fix = w_div_acc[AW-1] ? (w_div_acc[WIDTH-1:0] + r_m) : w_div_acc[WIDTH-1:0];
   assign w_quo     = r_neg_q ? ((~w_div_q) + WIDTH'(1)) : w_div_q;
   assign w_rem     = r_neg_r ? ((~w_rem_fix) + WIDTH'(1)) : w_rem_fix;

   always_comb begin
      w_state_nxt  = r_state;
      w_acc_nxt    = r_acc;
      w_q_nxt      = r_q;
      w_q1_nxt     = r_q1;
      w_m_nxt      = r_m;
      w_cnt_nxt    = r_cnt;
      w_is_div_nxt = r_is_div;
      w_neg_q_nxt  = r_neg_q;
      w_neg_r_nxt  = r_neg_r;
      w_hi_nxt     = r_hi;
      w_lo_nxt     = r_lo;
      w_dbz_nxt    = r_dbz;
      w_op_err_nxt = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            w_state_nxt  = S_IDLE;
            w_op_err_nxt = w_bad;
            if (w_accept) begin
               w_dbz_nxt    = 1'b0;
               w_is_div_nxt = w_is_divop;
               if (w_is_divop && (bus.b == '0)) begin
                  w_state_nxt = S_DONE;
                  w_hi_nxt    = bus.a;
                  w_lo_nxt    = '1;
                  w_dbz_nxt   = 1'b1;
               end else if (w_zero_skip) begin
                  w_state_nxt = S_DONE;
                  w_hi_nxt    = '0;
                  w_lo_nxt    = '0;
               end else begin
                  w_state_nxt = S_RUN;
                  w_cnt_nxt   = CW'(WIDTH);
                  w_acc_nxt   = '0;
                  w_q1_nxt    = 1'b0;
                  w_q_nxt     = w_is_divop ? w_a_abs : bus.b;
                  w_m_nxt     = w_is_divop ? w_b_abs : bus.a;
                  w_neg_q_nxt = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                  w_neg_r_nxt = bus.a[WIDTH-1];
               end
            end
         end
         S_RUN: begin
            w_cnt_nxt = r_cnt - CW'(1);
            w_q1_nxt  = r_q[0];
            w_acc_nxt = r_is_div ? w_div_acc : w_mul_acc;
            w_q_nxt   = r_is_div ? w_div_q : w_mul_q;
            if (r_cnt == CW'(1)) begin
               w_state_nxt = S_DONE;
               w_hi_nxt    = r_is_div ? w_rem : w_mul_acc[WIDTH-1:0];
               w_lo_nxt    = r_is_div ? w_quo : w_mul_q;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_busy_nxt = (w_state_nxt == S_RUN);
      w_done_nxt = (w_state_nxt == S_DONE);
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         r_acc    <= '0;
         r_q      <= '0;
         r_q1     <= 1'b0;
         r_m      <= '0;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_dbz    <= 1'b0;
         r_op_err <= 1'b0;
      end else begin
         r_acc    <= w_acc_nxt;
         r_q      <= w_q_nxt;
         r_q1     <= w_q1_nxt;
         r_m      <= w_m_nxt;
         r_cnt    <= w_cnt_nxt;
         r_is_div <= w_is_div_nxt;
         r_neg_q  <= w_neg_q_nxt;
         r_neg_r  <= w_neg_r_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_hi     <= w_hi_nxt;
         r_lo     <= w_lo_nxt;
         r_dbz    <= w_dbz_nxt;
         r_op_err <= w_op_err_nxt;
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.hi          = r_hi;
   assign bus.lo          = r_lo;
   assign bus.div_by_zero = r_dbz;
   assign bus.op_err      = r_op_err;
endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Directed bench for seq_muldiv_unit at WIDTH=32 with hand-computed HI/LO results.
module tb_seq_muldiv_unit;
   localparam logic [4:0] OPM = 5'b01111;
   localparam logic [4:0] OPD = 5'b10000;

   logic clk;
   logic clear;
   int   total = 0;
   int   bad   = 0;

   seq_muldiv_unit_if #(.WIDTH(32), .OPW(5)) bus ();

   seq_muldiv_unit #(.WIDTH(32), .OPW(5), .OP_MUL(OPM), .OP_DIV(OPD)) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one start pulse; return negedges from acceptance until done, and busy cycles seen.
   task automatic do_op(input logic [4:0] op, input logic [31:0] va, input logic [31:0] vb,
                        output int lat, output int bc);
      @(negedge clk);
      bus.start = 1'b1; bus.opcode = op; bus.a = va; bus.b = vb;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1; bc = 0;
      while (!bus.done && lat < 200) begin
         if (bus.busy) bc++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      clear = 1'b0;
      bus.start = 1'b0; bus.opcode = '0; bus.a = '0; bus.b = '0;
      #12;
      total++;
      if ({bus.busy, bus.done, bus.div_by_zero, bus.op_err} !== 4'b0000) begin
         bad++; $display("FAIL reset_flags got=%b want=0000", {bus.busy, bus.done, bus.div_by_zero, bus.op_err});
      end
      total++;
      if ({bus.hi, bus.lo} !== 64'h0) begin
         bad++; $display("FAIL reset_hilo got=%h want=0", {bus.hi, bus.lo});
      end
      @(negedge clk);
      clear = 1'b1;
   endtask

   task automatic test_mul;
      int lat, bc;
      do_op(OPM, 32'hFFFF_FFFD, 32'd7, lat, bc);
      total++;
      if (lat !== 33) begin bad++; $display("FAIL mul_latency got=%0d want=33", lat); end
      total++;
      if (bc !== 32) begin bad++; $display("FAIL mul_busy_cycles got=%0d want=32", bc); end
      total++;
      if (bus.hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mul_hi got=%h want=ffffffff", bus.hi); end
      total++;
      if (bus.lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_lo got=%h want=ffffffeb", bus.lo); end
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0) begin bad++; $display("FAIL mul_done_pulse got=%b want=0", bus.done); end
   endtask

   task automatic test_div;
      int lat, bc;
      do_op(OPD, 32'hFFFF_FFEF, 32'd5, lat, bc);
      total++;
      if (lat !== 33) begin bad++; $display("FAIL div_latency got=%0d want=33", lat); end
      total++;
      if (bus.lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_quot got=%h want=fffffffd", bus.lo); end
      total++;
      if (bus.hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL div_rem got=%h want=fffffffe", bus.hi); end
      do_op(OPD, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
      total++;
      if (bus.lo !== 32'h8000_0000) begin bad++; $display("FAIL div_minneg_quot got=%h want=80000000", bus.lo); end
      total++;
      if (bus.hi !== 32'h0) begin bad++; $display("FAIL div_minneg_rem got=%h want=0", bus.hi); end
      total++;
      if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL div_minneg_dbz got=%b want=0", bus.div_by_zero); end
   endtask

   task automatic test_div_zero;
      int lat, bc;
      do_op(OPD, 32'd123, 32'd0, lat, bc);
      total++;
      if (lat !== 1) begin bad++; $display("FAIL dbz_latency got=%0d want=1", lat); end
      total++;
      if (bc !== 0) begin bad++; $display("FAIL dbz_busy got=%0d want=0", bc); end
      total++;
      if (bus.div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b want=1", bus.div_by_zero); end
      total++;
      if (bus.hi !== 32'd123) begin bad++; $display("FAIL dbz_hi got=%h want=0000007b", bus.hi); end
      total++;
      if (bus.lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dbz_lo got=%h want=ffffffff", bus.lo); end
      @(negedge clk);
      total++;
      if ({bus.div_by_zero, bus.done} !== 2'b10) begin
         bad++; $display("FAIL dbz_hold got=%b want=10", {bus.div_by_zero, bus.done});
      end
   endtask

   task automatic test_back_to_back;
      int n;
      bit err_seen;
      err_seen = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.opcode = OPM; bus.a = 32'd6; bus.b = 32'd7;
      @(posedge clk);
      @(negedge clk);
      n = 1;
      while (!bus.done && n < 200) begin
         if (bus.op_err) err_seen = 1'b1;
         if (n == 10) begin bus.a = 32'd1; bus.b = 32'd1; end
         if (n == 20) bus.opcode = 5'b00000;
         if (n == 21) bus.opcode = OPM;
         @(negedge clk);
         n++;
      end
      total++;
      if (n !== 33) begin bad++; $display("FAIL b2b_first_latency got=%0d want=33", n); end
      total++;
      if ({bus.hi, bus.lo} !== {32'd0, 32'd42}) begin
         bad++; $display("FAIL b2b_first_result got=%h want=%h", {bus.hi, bus.lo}, {32'd0, 32'd42});
      end
      total++;
      if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL b2b_dbz_cleared got=%b want=0", bus.div_by_zero); end
      total++;
      if (err_seen !== 1'b0) begin bad++; $display("FAIL b2b_busy_op_err got=%b want=0", err_seen); end
      bus.opcode = OPD; bus.a = 32'd100; bus.b = 32'd7;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      total++;
      if ({bus.busy, bus.done} !== 2'b10) begin
         bad++; $display("FAIL b2b_no_bubble got=%b want=10", {bus.busy, bus.done});
      end
      n = 1;
      while (!bus.done && n < 200) begin
         if (n == 5) bus.start = 1'b1;
         if (n == 6) bus.start = 1'b0;
         @(negedge clk);
         n++;
      end
      total++;
      if (n !== 33) begin bad++; $display("FAIL b2b_second_latency got=%0d want=33", n); end
      total++;
      if (bus.lo !== 32'd14) begin bad++; $display("FAIL b2b_quot got=%h want=0000000e", bus.lo); end
      total++;
      if (bus.hi !== 32'd2) begin bad++; $display("FAIL b2b_rem got=%h want=00000002", bus.hi); end
   endtask

   task automatic test_bad_opcode;
      @(negedge clk);
      bus.start = 1'b1; bus.opcode = 5'b00000; bus.a = 32'd9; bus.b = 32'd9;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      total++;
      if ({bus.op_err, bus.busy, bus.done} !== 3'b100) begin
         bad++; $display("FAIL badop_flags got=%b want=100", {bus.op_err, bus.busy, bus.done});
      end
      total++;
      if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin
         bad++; $display("FAIL badop_hilo_kept got=%h want=%h", {bus.hi, bus.lo}, {32'd2, 32'd14});
      end
      @(negedge clk);
      total++;
      if ({bus.op_err, bus.busy} !== 2'b00) begin
         bad++; $display("FAIL badop_pulse got=%b want=00", {bus.op_err, bus.busy});
      end
   endtask

   task automatic test_reset_mid_run;
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.opcode = OPM; bus.a = 32'd7; bus.b = 32'd9;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      #2 clear = 1'b0;
      #1;
      total++;
      if ({bus.busy, bus.done} !== 2'b00) begin
         bad++; $display("FAIL midrun_reset_flags got=%b want=00", {bus.busy, bus.done});
      end
      total++;
      if ({bus.hi, bus.lo} !== 64'h0) begin
         bad++; $display("FAIL midrun_reset_hilo got=%h want=0", {bus.hi, bus.lo});
      end
      @(negedge clk);
      clear = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL midrun_no_done got=%b want=0", seen); end
   endtask

   task automatic test_zero_skip;
      int lat, bc;
      do_op(OPM, 32'd0, 32'd5, lat, bc);
`ifdef MULDIV_ZERO_SKIP_EN
      total++;
      if (lat !== 1) begin bad++; $display("FAIL zero_latency got=%0d want=1", lat); end
      total++;
      if (bc !== 0) begin bad++; $display("FAIL zero_busy got=%0d want=0", bc); end
`else
      total++;
      if (lat !== 33) begin bad++; $display("FAIL zero_latency got=%0d want=33", lat); end
      total++;
      if (bc !== 32) begin bad++; $display("FAIL zero_busy got=%0d want=32", bc); end
`endif
      total++;
      if ({bus.hi, bus.lo} !== 64'h0) begin
         bad++; $display("FAIL zero_result got=%h want=0", {bus.hi, bus.lo});
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
      test_back_to_back();
      test_bad_opcode();
      test_reset_mid_run();
      test_zero_skip();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seq_muldiv_unit.md
Name: seq_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit feeding the HI/LO registers of the CPU datapath. It replaces single-cycle multiply/divide with a start/done sequential engine: signed radix-2 Booth multiply and signed non-restoring divide, one iteration per clock. Operand width and opcode encodings are parameters, so the same block serves the 32-bit datapath and narrower test configurations.

Parameters:
- WIDTH, 32, operand width; hi/lo are WIDTH each; legal range 4..64.
- OPW, 5, opcode width, matching datapath opcode field.
- OP_MUL, 5'b01111, opcode selecting signed multiply.
- OP_DIV, 5'b10000, opcode selecting signed divide.

Ports:
- clk  in  1  system clock, rising-edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled on rising clk edge.
- opcode  in  OPW  operation select, sampled with start.
- a  in  WIDTH  multiplicand / dividend, sampled with start.
- b  in  WIDTH  multiplier / divisor, sampled with start.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse; hi/lo valid.
- hi  out  WIDTH  MUL: upper product half; DIV: remainder.
- lo  out  WIDTH  MUL: lower product half; DIV: quotient.
- div_by_zero  out  1  high with done when DIV had b==0.
- op_err  out  1  one-cycle pulse: start with unsupported opcode.

Behaviour:
- Reset (clear=0, any time incl. mid-operation): state IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0, op_err=0; iteration counter 0. Takes effect immediately, no clock needed.
- States: IDLE, RUN, DONE.
- IDLE: start=1 with OP_MUL/OP_DIV -> latch a,b,opcode; go RUN; counter=WIDTH. start=1 with other opcode -> op_err=1 for next cycle, stay IDLE, hi/lo unchanged.
- RUN: busy=1; one Booth or non-restoring step per cycle; counter decrements; when counter reaches 1, next edge goes DONE. Exactly WIDTH cycles in RUN.
- DONE: busy=0, done=1 for exactly one cycle; hi/lo updated on the edge entering DONE and held until the edge entering the next DONE. Next state IDLE, or RUN if start with valid opcode is sampled in DONE (back-to-back, no bubble).
- Latency: start sampled at edge E0 -> busy=1 after E0..E0+WIDTH -> done=1 after E0+WIDTH for one cycle.
- start while busy: ignored, no op_err, operands not relatched.
- MUL: {hi,lo} = signed(a) * signed(b), full 2*WIDTH result, no overflow.
- DIV: lo = quotient truncated toward zero; hi = remainder, sign of dividend; a == lo*b + hi.
- DIV most-negative / -1: lo = most-negative value (wraps), hi=0, no flag.
- DIV b==0: skip RUN; DONE on next edge after start; hi=a, lo=all ones, div_by_zero=1 during done; div_by_zero cleared on next accepted start or reset.
- op_err and done never high in same cycle as a fresh op_err from ignored start (ignored starts produce nothing).

Optional Feature:
- Macro: MULDIV_ZERO_SKIP_EN.
- Defined: MUL with a==0 or b==0, or DIV with a==0 and b!=0, skips RUN; DONE on next edge after start with hi=0, lo=0; busy never asserts.
- Undefined: these cases take full WIDTH RUN cycles; results identical (hi=0, lo=0). Only latency differs.

Test Plan:
- Reset: clear=0 mid-RUN of MUL 7*9 -> busy,done,hi,lo all 0 immediately; after clear=1 no done pulse appears.
- MUL a=-3 (0xFFFFFFFD), b=7 -> busy 32 cycles, done after edge E0+32: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=-17, b=5 -> done after E0+32: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFE (-2); DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=123, b=0 -> done one cycle after start, div_by_zero=1, hi=123, lo=0xFFFFFFFF, busy never high.
- Back-to-back: start MUL 6*7 held through done, next DIV 100/7 sampled in DONE -> first done lo=42,hi=0; second done 32 cycles later lo=14, hi=2; start pulses during busy ignored.
- Bad opcode 5'b00000 with start -> op_err pulse one cycle, hi/lo keep prior values, busy stays 0; with MULDIV_ZERO_SKIP_EN, MUL 0*5 -> done next cycle, hi=lo=0.
